pwm_ramp_controller: RTL and testbench

- Sequences the PWM generator from the 32-bit PWM control word written by the soft-core through its PIO.
- Decodes commands and ramps duty toward a target with a controlled slew.
- Generates the PWM output and returns an 8-bit status word to the status PIO.
- Sits between the control PIO (output) and status PIO (input) in the top-level design, all in the system clock domain.

---
 rtl/pwm_ramp_controller.sv | 82 ++++++++
 tb/tb_pwm_ramp_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: toggle-handshaked command decode, slew-limited duty ramp, PWM generation and status echo
module pwm_ramp_controller #(
  parameter int RAMP_DIV = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      pwm_ctrl,
  output logic [7:0]       pwm_status,
  output logic             pwm_out,
  output logic [CNT_W-1:0] duty_cur
);
  typedef enum logic [1:0] {IDLE, RAMP, RUN, STOP} state_t;
  localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);
  state_t state, state_nxt;
  logic last_toggle, cmd_det, tick, wrap, step_evt, running, unused_ctrl;
  logic [7:0] presc, presc_act, presc_cnt, div_cnt;
  logic [CNT_W-1:0] target, step, pwm_cnt, goal, duty_step, duty_nxt;
  logic [CNT_W:0] up, dn;
  assign unused_ctrl = ^pwm_ctrl[30:25];
  assign tick = presc_cnt == presc_act;
  assign wrap = tick && &pwm_cnt;
  assign step_evt = wrap && div_cnt == DIV_LAST;
  assign running = state != IDLE;
  // 9-bit sums clamp at the goal so the duty never overshoots or wraps
  always_comb begin
    goal = state == STOP ? '0 : target;
    up = {1'b0, duty_cur} + {1'b0, step};
    dn = {1'b0, duty_cur} - {1'b0, step};
    duty_step = step == '0 ? goal
              : duty_cur < goal ? (up > {1'b0, goal} ? goal : up[CNT_W-1:0])
              : (dn[CNT_W] || dn[CNT_W-1:0] < goal ? goal : dn[CNT_W-1:0]);
    duty_nxt = step_evt && running ? duty_step : duty_cur;
  end
  // a command decides against the duty that this edge will leave in place
  always_comb begin
    state_nxt = state;
    if (cmd_det)
      state_nxt = pwm_ctrl[24] ? (pwm_ctrl[CNT_W-1:0] == duty_nxt ? RUN : RAMP)
                               : (state == IDLE ? IDLE : STOP);
    else if (state == RAMP && step_evt && duty_nxt == target)
      state_nxt = RUN;
    else if (state == STOP && step_evt && duty_nxt == '0)
      state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last_toggle <= 1'b0;
      cmd_det <= 1'b0;
      target <= '0;
      presc <= '0;
      step <= '0;
      presc_act <= '0;
      presc_cnt <= '0;
      div_cnt <= '0;
      pwm_cnt <= '0;
      duty_cur <= '0;
      pwm_out <= 1'b0;
      pwm_status <= '0;
    end else begin
      state <= state_nxt;
      cmd_det <= (pwm_ctrl[31] != last_toggle) && !cmd_det;
      if (cmd_det) begin
        last_toggle <= pwm_ctrl[31];
        target <= pwm_ctrl[CNT_W-1:0];
        presc <= pwm_ctrl[15:8];
        step <= pwm_ctrl[23:16];
      end
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) begin
        presc_act <= presc;
        div_cnt <= step_evt ? '0 : div_cnt + 1'b1;
      end
      duty_cur <= duty_nxt;
      pwm_out <= running && pwm_cnt < duty_cur;
      pwm_status <= {duty_cur[CNT_W-1:CNT_W-4], cmd_det ? pwm_ctrl[31] : pwm_status[3],
                     running && duty_cur == target, running, state == RAMP || state == STOP};
    end
  end
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb_pwm_ramp_controller: directed checks of command handshake, ramping, saturation, prescaler and reset
module tb_pwm_ramp_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] pwm_ctrl = '0;
  logic [7:0] pwm_status, duty_cur;
  logic pwm_out;
  int e, n_checks, n_fail, h;

  pwm_ramp_controller #(.RAMP_DIV(1), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .pwm_ctrl(pwm_ctrl),
    .pwm_status(pwm_status), .pwm_out(pwm_out), .duty_cur(duty_cur)
  );

  always #5 clk = ~clk;
  always @(posedge clk or negedge reset_n) e <= !reset_n ? 0 : e + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic wait_e(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_status", pwm_status, 8'h00);
    check("rst_duty", duty_cur, 8'h00);
    check("rst_out", pwm_out, 1'b0);
    reset_n = 1'b1;
    wait_e(1);
    check("rel_status", pwm_status, 8'h00);
    check("rel_duty", duty_cur, 8'h00);
    wait_e(2);
    pwm_ctrl = 32'h8101_0080;
    wait_e(3);
    check("ack_early", pwm_status, 8'h00);
    wait_e(4);
    check("ack_echo", pwm_status, 8'h08);
    wait_e(5);
    check("ramp_status", pwm_status, 8'h0B);
    wait_e(255);
    check("pre_wrap_duty", duty_cur, 8'h00);
    wait_e(256);
    check("wrap1_duty", duty_cur, 8'h01);
    wait_e(2600);
    check("wrap10_duty", duty_cur, 8'h0A);
    wait_e(32767);
    check("wrap127_duty", duty_cur, 8'h7F);
    wait_e(32768);
    check("reach_80", duty_cur, 8'h80);
    wait_e(32770);
    check("run_status", pwm_status, 8'h8E);
    wait_e(32999);
    count_high(256, h);
    check("high_80", h, 128);
    wait_e(33300);
    pwm_ctrl = 32'h0010_0000;
    wait_e(33536);
    check("stop_70", duty_cur, 8'h70);
    wait_e(33540);
    check("stop_status", pwm_status, 8'h73);
    wait_e(35327);
    check("stop_10", duty_cur, 8'h10);
    wait_e(35330);
    check("idle_duty", duty_cur, 8'h00);
    check("idle_status", pwm_status, 8'h00);
    check("idle_out", pwm_out, 1'b0);
    wait_e(35400);
    pwm_ctrl = 32'h8100_00F0;
    wait_e(35583);
    check("jump_pre", duty_cur, 8'h00);
    wait_e(35584);
    check("jump_f0", duty_cur, 8'hF0);
    wait_e(35600);
    pwm_ctrl = 32'h0130_00FF;
    wait_e(35840);
    check("sat_ff", duty_cur, 8'hFF);
    wait_e(35842);
    check("sat_status", pwm_status, 8'hF6);
    wait_e(35899);
    count_high(256, h);
    check("high_ff", h, 255);
    wait_e(36160);
    pwm_ctrl = 32'h8100_0020;
    wait_e(36352);
    check("set_20", duty_cur, 8'h20);
    wait_e(36400);
    pwm_ctrl = 32'h0110_0080;
    wait_e(36608);
    check("rise_30", duty_cur, 8'h30);
    wait_e(36650);
    pwm_ctrl = 32'h8110_0010;
    wait_e(36863);
    check("hold_30", duty_cur, 8'h30);
    wait_e(36864);
    check("rev_20", duty_cur, 8'h20);
    wait_e(36900);
    check("rev_status", pwm_status, 8'h2B);
    wait_e(37119);
    check("hold_20", duty_cur, 8'h20);
    wait_e(37120);
    check("rev_10", duty_cur, 8'h10);
    wait_e(37122);
    check("rev_done", pwm_status, 8'h1E);
    wait_e(37150);
    pwm_ctrl = 32'h0100_0340;
    wait_e(37376);
    check("presc_duty", duty_cur, 8'h40);
    wait_e(37399);
    count_high(1024, h);
    check("high_presc3", h, 256);
    wait_e(38450);
    pwm_ctrl = 32'h8100_0040;
    wait_e(38560);
    check("presc_deferred", pwm_out, 1'b1);
    wait_e(39424);
    check("presc_hold_duty", duty_cur, 8'h40);
    count_high(256, h);
    check("high_presc0", h, 64);
    wait_e(39690);
    pwm_ctrl = 32'h0110_0080;
    wait_e(39700);
    check("pre_rst_out", pwm_out, 1'b1);
    check("pre_rst_duty", duty_cur, 8'h40);
    check("pre_rst_status", pwm_status, 8'h43);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out", pwm_out, 1'b0);
    check("async_duty", duty_cur, 8'h00);
    check("async_status", pwm_status, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_e(1);
    check("rel2_status", pwm_status, 8'h00);
    check("rel2_out", pwm_out, 1'b0);
    wait_e(300);
    check("rel2_duty", duty_cur, 8'h00);
    check("rel2_idle", pwm_status, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
